vis_bank_fetch: RTL and testbench

Downstream of the correlator bank/switch controller. When the controller pulses its bank-switch strobe, this block latches the index of the just-completed visibility bank and reads all COUNT accumulator words from the visibilities SRAM, using a 1-cycle read latency. It streams the words out with a valid/ready handshake to the readback block buffer. Switches that arrive while a fetch is in progress are queued one deep; any further switches are counted as overflows.

---
 rtl/vis_bank_fetch.sv | 170 +++++++++++++++++
 tb/tb_vis_bank_fetch.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vis_bank_fetch.sv
// Bank readback fetcher: on a bank-switch strobe, reads every accumulator word of the
// just-completed visibility bank from SRAM and streams it out through a 2-entry skid buffer.
module vis_bank_fetch #(
    parameter int ACCUM = 24,
    parameter int BANKS = 16,
    parameter int BSB   = 4,
    parameter int COUNT = 24,
    parameter int CBITS = 5,
    parameter int ABITS = 9
) (
    input  logic             clk_x,
    input  logic             rst_n,
    input  logic             sw_i,
    input  logic [BSB-1:0]   bank_i,
    output logic             sram_rd_o,
    output logic [ABITS-1:0] sram_adr_o,
    input  logic [ACCUM-1:0] sram_dat_i,
    output logic             vld_o,
    input  logic             rdy_i,
    output logic [ACCUM-1:0] dat_o,
    output logic             last_o,
    output logic [BSB-1:0]   tag_o,
    output logic             busy_o,
    output logic             ovf_o,
    output logic [7:0]       ovf_cnt_o
);

    localparam logic [BSB-1:0]   TOP_BANK = BSB'(BANKS - 1);
    localparam logic [CBITS-1:0] LAST_W   = CBITS'(COUNT - 1);

    typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

    state_t             state_q;
    logic [BSB-1:0]     tag_q;
    logic [BSB-1:0]     pend_bank_q;
    logic               pend_q;
    logic [CBITS-1:0]   word_q;
    logic               ovf_q;
    logic [7:0]         ovf_cnt_q;

    logic               vld_p1;
    logic               last_p1;

    logic [1:0]         cnt_p2;
    logic [ACCUM-1:0]   dat0_p2;
    logic [ACCUM-1:0]   dat1_p2;
    logic               last0_p2;
    logic               last1_p2;

    logic               push;
    logic               pop;
    logic [1:0]         held;
    logic               room;
    logic               issue;
    logic               done;
    logic               queue_sw;
    logic [BSB-1:0]     done_bank;

    function automatic logic [BSB-1:0] completed_bank(input logic [BSB-1:0] b);
        return (b == '0) ? TOP_BANK : b - BSB'(1);
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] c);
        return (c == 8'hFF) ? c : c + 8'd1;
    endfunction

    // A pop in the current cycle frees a slot, which is what lets the stream run at 1 word/cycle.
    always_comb begin
        done_bank = completed_bank(bank_i);
        push      = vld_p1;
        pop       = (cnt_p2 != 2'd0) && rdy_i;
        held      = cnt_p2 + {1'b0, vld_p1};
        room      = held <= (2'd1 + {1'b0, pop});
        issue     = (state_q == READ) && room;
        done      = (state_q == DRAIN) && (cnt_p2 == 2'd1) && !vld_p1 && pop && last0_p2;
        queue_sw  = sw_i && ((state_q == READ) || ((state_q == DRAIN) && !done));
    end

    assign sram_rd_o  = issue;
    assign sram_adr_o = issue ? {tag_q, word_q} : '0;
    assign vld_o      = (cnt_p2 != 2'd0);
    assign dat_o      = vld_o ? dat0_p2 : '0;
    assign last_o     = vld_o && last0_p2;
    assign tag_o      = tag_q;
    assign busy_o     = (state_q != IDLE);
    assign ovf_o      = ovf_q;
    assign ovf_cnt_o  = ovf_cnt_q;

    always_ff @(posedge clk_x or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            tag_q       <= '0;
            pend_bank_q <= '0;
            pend_q      <= 1'b0;
            word_q      <= '0;
            ovf_q       <= 1'b0;
            ovf_cnt_q   <= 8'd0;
            vld_p1      <= 1'b0;
            last_p1     <= 1'b0;
            cnt_p2      <= 2'd0;
        end else begin
            // p0 -> p1: read issued, data returns from SRAM next cycle
            vld_p1  <= issue;
            last_p1 <= issue && (word_q == LAST_W);
            // p1 -> p2: returning word lands in the skid buffer
            cnt_p2  <= cnt_p2 + {1'b0, push} - {1'b0, pop};

            if (queue_sw) begin
                if (!pend_q) begin
                    pend_q      <= 1'b1;
                    pend_bank_q <= done_bank;
                end else begin
                    ovf_q     <= 1'b1;
                    ovf_cnt_q <= sat_inc(ovf_cnt_q);
                end
            end

            case (state_q)
                IDLE: begin
                    if (sw_i) begin
                        tag_q   <= done_bank;
                        word_q  <= '0;
                        state_q <= READ;
                    end
                end
                READ: begin
                    if (issue) begin
                        word_q <= word_q + CBITS'(1);
                        if (word_q == LAST_W) state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    // The pending slot frees as it is consumed, so a coincident strobe refills it.
                    if (done) begin
                        if (pend_q) begin
                            tag_q   <= pend_bank_q;
                            word_q  <= '0;
                            state_q <= READ;
                            pend_q  <= sw_i;
                            if (sw_i) pend_bank_q <= done_bank;
                        end else if (sw_i) begin
                            tag_q   <= done_bank;
                            word_q  <= '0;
                            state_q <= READ;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Skid storage: entry 0 is always the head; entry 1 fills only while the head is held.
    always_ff @(posedge clk_x) begin
        if (push && ((cnt_p2 == 2'd0) || ((cnt_p2 == 2'd1) && pop))) begin
            dat0_p2  <= sram_dat_i;
            last0_p2 <= last_p1;
        end else if (pop) begin
            dat0_p2  <= dat1_p2;
            last0_p2 <= last1_p2;
        end
        if (push && (((cnt_p2 == 2'd1) && !pop) || ((cnt_p2 == 2'd2) && pop))) begin
            dat1_p2  <= sram_dat_i;
            last1_p2 <= last_p1;
        end
    end

endmodule

// File: tb/tb_vis_bank_fetch.sv
// Randomized bench for vis_bank_fetch with a stream-level reference model and SRAM model.
module tb_vis_bank_fetch;

    localparam int ACCUM = 24;
    localparam int BANKS = 16;
    localparam int BSB   = 4;
    localparam int COUNT = 24;
    localparam int CBITS = 5;
    localparam int ABITS = 9;

    logic             clk_x = 1'b0;
    logic             rst_n = 1'b0;
    logic             sw_i  = 1'b0;
    logic [BSB-1:0]   bank_i = '0;
    logic             sram_rd_o;
    logic [ABITS-1:0] sram_adr_o;
    logic [ACCUM-1:0] sram_dat_i = '0;
    logic             vld_o;
    logic             rdy_i = 1'b0;
    logic [ACCUM-1:0] dat_o;
    logic             last_o;
    logic [BSB-1:0]   tag_o;
    logic             busy_o;
    logic             ovf_o;
    logic [7:0]       ovf_cnt_o;

    vis_bank_fetch #(
        .ACCUM(ACCUM), .BANKS(BANKS), .BSB(BSB),
        .COUNT(COUNT), .CBITS(CBITS), .ABITS(ABITS)
    ) dut (
        .clk_x(clk_x), .rst_n(rst_n), .sw_i(sw_i), .bank_i(bank_i),
        .sram_rd_o(sram_rd_o), .sram_adr_o(sram_adr_o), .sram_dat_i(sram_dat_i),
        .vld_o(vld_o), .rdy_i(rdy_i), .dat_o(dat_o), .last_o(last_o),
        .tag_o(tag_o), .busy_o(busy_o), .ovf_o(ovf_o), .ovf_cnt_o(ovf_cnt_o)
    );

    always #5 clk_x = ~clk_x;

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    logic [ACCUM-ABITS-1:0] salt = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [ACCUM-1:0] mem_word(input int adr);
        return {salt, ABITS'(adr)};
    endfunction

    // SRAM: one-cycle read latency
    always @(posedge clk_x) begin
        if (sram_rd_o) sram_dat_i <= mem_word(int'(sram_adr_o));
    end

    // Reference model: which bank is streaming, which word is next, the one-deep queue, drops.
    logic             m_busy = 1'b0;
    logic             m_pend = 1'b0;
    int               m_pend_bank = 0;
    int               m_tag = 0;
    int               m_idx = 0;
    int               m_ovf = 0;
    int               cb;
    logic             endw;
    logic             prev_stall = 1'b0;
    logic [ACCUM-1:0] prev_dat = '0;
    logic             prev_last = 1'b0;
    int               done_tags[$];

    always @(negedge clk_x) begin
        if (!rst_n) begin
            m_busy = 1'b0; m_pend = 1'b0; m_pend_bank = 0;
            m_tag = 0; m_idx = 0; m_ovf = 0; prev_stall = 1'b0;
        end else begin
            cb = (int'(bank_i) + BANKS - 1) % BANKS;
            chk("busy", busy_o, m_busy);
            chk("ovf_cnt", ovf_cnt_o, m_ovf);
            chk("ovf_flag", ovf_o, m_ovf != 0);
            if (!m_busy) chk("idle_vld", vld_o, 0);
            if (prev_stall) begin
                chk("stall_vld", vld_o, 1);
                chk("stall_dat", dat_o, prev_dat);
                chk("stall_last", last_o, prev_last);
            end
            endw = 1'b0;
            if (vld_o && rdy_i && m_busy) begin
                chk("dat", dat_o, mem_word(m_tag * (1 << CBITS) + m_idx));
                chk("tag", tag_o, m_tag);
                chk("last", last_o, m_idx == COUNT - 1);
                if (m_idx == COUNT - 1) begin
                    endw = 1'b1;
                    done_tags.push_back(m_tag);
                    m_idx = 0;
                end else m_idx++;
            end
            prev_stall = vld_o && !rdy_i;
            prev_dat   = dat_o;
            prev_last  = last_o;

            if (!m_busy) begin
                if (sw_i) begin m_busy = 1'b1; m_tag = cb; m_idx = 0; end
            end else if (endw) begin
                if (m_pend) begin
                    m_tag = m_pend_bank; m_idx = 0;
                    m_pend = sw_i; m_pend_bank = cb;
                end else if (sw_i) begin
                    m_tag = cb; m_idx = 0;
                end else m_busy = 1'b0;
            end else if (sw_i) begin
                if (!m_pend) begin m_pend = 1'b1; m_pend_bank = cb; end
                else if (m_ovf < 255) m_ovf++;
            end
        end
    end

    task automatic tick();
        @(posedge clk_x);
        #1;
    endtask

    task automatic pulse(input int b);
        sw_i = 1'b1;
        bank_i = BSB'(b);
        tick();
        sw_i = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int k = 0;
        while (busy_o && k < budget) begin
            tick();
            k++;
        end
        chk("idle_timeout", busy_o, 0);
    endtask

    task automatic chk_tags(input string tag, input int n, input int t0, input int t1);
        chk({tag, "_count"}, done_tags.size(), n);
        if (done_tags.size() >= 1) chk({tag, "_first"}, done_tags[0], t0);
        if (n >= 2 && done_tags.size() >= 2) chk({tag, "_second"}, done_tags[1], t1);
    endtask

    int lat;

    initial begin
        salt = (ACCUM-ABITS)'($urandom_range(0, 32767));
        repeat (3) tick();
        chk("rst_vld", vld_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_rd", sram_rd_o, 0);
        chk("rst_adr", sram_adr_o, 0);
        chk("rst_dat", dat_o, 0);
        chk("rst_last", last_o, 0);
        chk("rst_tag", tag_o, 0);
        chk("rst_ovf", ovf_o, 0);
        chk("rst_ovf_cnt", ovf_cnt_o, 0);
        rst_n = 1'b1;
        tick();

        // Single fetch, latency and first address
        rdy_i = 1'b1;
        sw_i = 1'b1;
        bank_i = 4'd3;
        @(negedge clk_x);
        @(posedge clk_x);
        #1;
        sw_i = 1'b0;
        lat = 1;
        @(negedge clk_x);
        chk("first_rd", sram_rd_o, 1);
        chk("first_adr", sram_adr_o, 64);
        while (!vld_o && lat < 10) begin
            @(negedge clk_x);
            lat++;
        end
        chk("latency", lat, 3);
        chk("tag_b3", tag_o, 2);
        wait_idle(100);
        chk_tags("single", 1, 2, 0);

        // Wrap from bank 0
        done_tags.delete();
        pulse(0);
        @(negedge clk_x);
        chk("wrap_adr", sram_adr_o, 480);
        chk("wrap_tag", tag_o, 15);
        wait_idle(100);
        chk_tags("wrap", 1, 15, 0);

        // Backpressure 1,0,0,1
        done_tags.delete();
        pulse(1);
        for (int k = 0; k < 300 && busy_o; k++) begin
            rdy_i = (k % 4 == 0) || (k % 4 == 3);
            tick();
        end
        rdy_i = 1'b1;
        wait_idle(50);
        chk_tags("bp", 1, 0, 0);

        // One-deep queue
        done_tags.delete();
        pulse(5);
        repeat (5) tick();
        pulse(6);
        wait_idle(200);
        chk_tags("queue", 2, 4, 5);
        chk("queue_ovf", ovf_o, 0);

        // Overflow
        done_tags.delete();
        pulse(7);
        repeat (3) tick();
        pulse(8);
        pulse(9);
        chk("ovf_one", ovf_cnt_o, 1);
        chk("ovf_flag_set", ovf_o, 1);
        pulse(10);
        chk("ovf_two", ovf_cnt_o, 2);
        wait_idle(200);
        chk_tags("ovf", 2, 6, 7);

        // Saturation of the drop counter while the stream is stalled
        done_tags.delete();
        rdy_i = 1'b0;
        pulse(1);
        sw_i = 1'b1;
        for (int k = 0; k < 260; k++) begin
            bank_i = BSB'($urandom_range(0, BANKS - 1));
            tick();
        end
        sw_i = 1'b0;
        chk("ovf_sat", ovf_cnt_o, 255);
        rdy_i = 1'b1;
        wait_idle(200);
        chk("sat_streams", done_tags.size(), 2);

        // Reset mid-fetch
        done_tags.delete();
        pulse(11);
        for (int k = 0; k < 100 && m_idx < 10; k++) tick();
        chk("pre_rst_busy", busy_o, 1);
        rst_n = 1'b0;
        #1;
        chk("abort_vld", vld_o, 0);
        chk("abort_busy", busy_o, 0);
        chk("abort_rd", sram_rd_o, 0);
        chk("abort_ovf_cnt", ovf_cnt_o, 0);
        tick();
        rst_n = 1'b1;
        tick();
        done_tags.delete();
        pulse(12);
        wait_idle(100);
        chk_tags("post_rst", 1, 11, 0);

        // Random traffic
        for (int k = 0; k < 1500; k++) begin
            rdy_i  = ($urandom_range(0, 3) != 0);
            sw_i   = ($urandom_range(0, 29) == 0);
            bank_i = BSB'($urandom_range(0, BANKS - 1));
            tick();
        end
        sw_i  = 1'b0;
        rdy_i = 1'b1;
        wait_idle(300);
        chk("final_vld", vld_o, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
